channel_fifo: RTL and testbench

Synchronous FIFO channel that sits between a producer stage and a consumer stage such as the channel-reduce kernels. It buffers words written through a valid/ready write port and delivers them in order through a registered read port. Its read-side handshake matches what the generated consumer FSMs expect: wait for `read_ready`, pulse `read_valid` for one cycle, then sample `out_data` on the following cycle.

---
 rtl/channel_fifo.sv | 107 ++++++++++
 tb/tb_channel_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_fifo.sv
// Synchronous FIFO channel: valid/ready write port, registered pop-to-out_data read port.
// Optional sticky overflow/underflow flags are built when CHANNEL_FIFO_STATS_EN is defined.
module channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     write_valid_i,
  output logic                     write_ready_o,
  output logic [WIDTH-1:0]         out_data_o,
  input  logic                     read_valid_i,
  output logic                     read_ready_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef CHANNEL_FIFO_STATS_EN
  ,
  output logic                     err_overflow_o,
  output logic                     err_underflow_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             empty, full, push, pop;

  // Full/empty come only from the registered count, so ready never depends on valid.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    push    = write_valid_i && !full;
    pop     = read_valid_i && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    out_d   = out_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      out_d  = mem_q[rptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  // Storage is not reset; stale entries become unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wptr_q] <= in_data_i;
    end
  end

  assign write_ready_o = !full;
  assign read_ready_o  = !empty;
  assign out_data_o    = out_q;
  assign count_o       = count_q;

`ifdef CHANNEL_FIFO_STATS_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (write_valid_i && full);
    err_udf_d = err_udf_q | (read_valid_i && empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_udf_q;
`endif

endmodule

// File: tb/tb_channel_fifo.sv
// Bench for channel_fifo: directed scenarios plus random traffic, checked by a
// queue-based reference model and a scoreboard monitor sampling on the falling edge.
module tb_channel_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             wv = 1'b0;
  logic             rv = 1'b0;
  logic             write_ready, read_ready;
  logic [WIDTH-1:0] out_data;
  logic [$clog2(DEPTH):0] count;
`ifdef CHANNEL_FIFO_STATS_EN
  logic             err_ovf, err_udf;
`endif

  channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_data_i     (din),
    .write_valid_i (wv),
    .write_ready_o (write_ready),
    .out_data_o    (out_data),
    .read_valid_i  (rv),
    .read_ready_o  (read_ready),
    .count_o       (count)
`ifdef CHANNEL_FIFO_STATS_EN
    ,
    .err_overflow_o  (err_ovf),
    .err_underflow_o (err_udf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a plain queue, updated on each rising edge.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_out = '0;
  bit               m_ovf = 1'b0;
  bit               m_udf = 1'b0;

  always @(posedge clk) begin
    bit acc_push, acc_pop;
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      last_out = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      acc_push = wv && (model_q.size() < DEPTH);
      acc_pop  = rv && (model_q.size() > 0);
      if (wv && !acc_push) m_ovf = 1'b1;
      if (rv && !acc_pop)  m_udf = 1'b1;
      if (acc_pop) exp_q.push_back(model_q.pop_front());
      if (acc_push) model_q.push_back(din);
    end
  end

  // Scoreboard monitor: one expected word is retired for every observed pop.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        last_out = exp_q.pop_front();
        check("sb_pop_data", out_data, last_out);
      end else begin
        check("sb_hold_data", out_data, last_out);
      end
      check("sb_count", count, model_q.size());
      check("sb_read_ready", read_ready, model_q.size() != 0);
      check("sb_write_ready", write_ready, model_q.size() != DEPTH);
`ifdef CHANNEL_FIFO_STATS_EN
      check("sb_err_overflow", err_ovf, m_ovf);
      check("sb_err_underflow", err_udf, m_udf);
`endif
    end
  end

  task automatic drive(input bit w, input bit r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst = 1'b0;
    wv  = w;
    rv  = r;
    din = d;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    wv  = 1'b0;
    rv  = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read_ready(input string name);
    int t = 0;
    while (!read_ready && t < 20) begin
      drive(0, 0, '0);
      t++;
    end
    check(name, t < 20, 1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_read_ready", read_ready, 0);
    check("rst_write_ready", write_ready, 1);
    check("rst_out_data", out_data, 0);
`ifdef CHANNEL_FIFO_STATS_EN
    check("rst_err_overflow", err_ovf, 0);
    check("rst_err_underflow", err_udf, 0);
`endif
    mon_en = 1'b1;

    // Pop latency: one-cycle pulses, data visible the cycle after
    for (int k = 1; k <= 4; k++) drive(1, 0, WIDTH'(k));
    drive(0, 0, '0);
    for (int k = 1; k <= 4; k++) begin
      wait_read_ready("pop_lat_ready_wait");
      drive(0, 1, '0);
      drive(0, 0, '0);
      check("pop_lat_data", out_data, k);
    end
    check("pop_lat_count", count, 0);
    check("pop_lat_read_ready", read_ready, 0);

    // Fill to full, overflow push dropped, drain in order
    for (int k = 0; k < DEPTH; k++) drive(1, 0, WIDTH'(k));
    drive(0, 0, '0);
    check("full_write_ready", write_ready, 0);
    check("full_count", count, DEPTH);
    drive(1, 0, 32'hDEAD);
    drive(0, 0, '0);
    check("full_drop_count", count, DEPTH);
`ifdef CHANNEL_FIFO_STATS_EN
    check("full_err_overflow", err_ovf, 1);
`endif
    for (int k = 0; k < DEPTH; k++) begin
      drive(0, 1, '0);
      after_edge();
      check("drain_data", out_data, k);
    end
    drive(0, 0, '0);
    check("drain_count", count, 0);

    // Simultaneous push and pop at count 8, across pointer wrap
    for (int k = 0; k < 8; k++) drive(1, 0, WIDTH'(100 + k));
    for (int j = 0; j < 20; j++) begin
      drive(1, 1, WIDTH'(200 + j));
      after_edge();
      check("simul_count", count, 8);
      check("simul_data", out_data, (j < 8) ? 100 + j : 200 + j - 8);
    end
    for (int k = 0; k < 8; k++) drive(0, 1, '0);
    drive(0, 0, '0);
    check("simul_drain_count", count, 0);

    // Pop when empty: out_data holds, push on same edge still accepted
    drive(1, 0, 32'd7);
    drive(0, 1, '0);
    drive(0, 0, '0);
    check("empty_pre_data", out_data, 7);
    drive(0, 1, '0);
    drive(0, 0, '0);
    check("empty_pop_data", out_data, 7);
    check("empty_pop_count", count, 0);
`ifdef CHANNEL_FIFO_STATS_EN
    check("empty_err_underflow", err_udf, 1);
`endif
    drive(1, 1, 32'd9);
    drive(0, 0, '0);
    check("empty_push_count", count, 1);
    check("empty_push_data", out_data, 7);
    drive(0, 1, '0);
    drive(0, 0, '0);
    check("empty_push_pop_data", out_data, 9);

    // Reset mid-stream
    for (int k = 0; k < 5; k++) drive(1, 0, WIDTH'(300 + k));
    drive(0, 0, '0);
    check("mid_pre_count", count, 5);
    do_reset(1);
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_data", out_data, 0);
    drive(1, 0, 32'h55);
    drive(0, 1, '0);
    drive(0, 0, '0);
    check("mid_post_data", out_data, 32'h55);

    // Random traffic with phases biased toward filling and draining
    for (int c = 0; c < 3000; c++) begin
      int wbias, rbias;
      wbias = ((c / 200) % 2 == 0) ? 80 : 35;
      rbias = ((c / 200) % 2 == 0) ? 35 : 80;
      if ($urandom_range(999, 0) == 0) begin
        do_reset(1);
      end else begin
        drive($urandom_range(99, 0) < wbias, $urandom_range(99, 0) < rbias, $urandom);
      end
    end
    drive(0, 0, '0);
    drive(0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
